// File: rtl/vga_ssd_render.sv
// Four-digit BCD seven-segment overlay for a VGA pixel stream. The count advances
// once every FRAMES_PER_TICK frames; rendering runs as a two-stage pixel pipeline.
module vga_ssd_render #(
    parameter int          ORG_X           = 64,
    parameter int          ORG_Y           = 160,
    parameter int          SEG_T           = 8,
    parameter int          SEG_L           = 48,
    parameter int          DIG_PITCH       = 96,
    parameter int          FRAMES_PER_TICK = 60,
    parameter logic [9:0]  FG_R            = 10'h3FF,
    parameter logic [9:0]  FG_G            = 10'h000,
    parameter logic [9:0]  FG_B            = 10'h000,
    parameter logic [9:0]  BG_R            = 10'h000,
    parameter logic [9:0]  BG_G            = 10'h000,
    parameter logic [9:0]  BG_B            = 10'h0FF
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [11:0] iX,
    input  logic [11:0] iY,
    input  logic        iVS,
    input  logic        iRUN,
    input  logic        iLOAD,
    input  logic [15:0] iLOAD_VAL,
    output logic [9:0]  oRed,
    output logic [9:0]  oGreen,
    output logic [9:0]  oBlue,
    output logic [15:0] oCOUNT
);
    localparam logic [11:0] OX     = 12'(ORG_X);
    localparam logic [11:0] OY     = 12'(ORG_Y);
    localparam logic [11:0] T      = 12'(SEG_T);
    localparam logic [11:0] L      = 12'(SEG_L);
    localparam logic [11:0] CELL_W = 12'(SEG_L + 2*SEG_T);
    localparam logic [11:0] CELL_H = 12'(2*SEG_L + 3*SEG_T);
    localparam int          FC_W   = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
    localparam logic [FC_W-1:0] FC_MAX = FC_W'(FRAMES_PER_TICK - 1);

    function automatic logic [15:0] bcdInc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] >= 4'd9) r[i*4 +: 4] = 4'd0;
                else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcdClean(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++)
            r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd0 : v[i*4 +: 4];
        return r;
    endfunction

    // Segment order {a,b,c,d,e,f,g}
    function automatic logic [6:0] segDecode(input logic [3:0] n);
        case (n)
            4'd0: segDecode = 7'b1111110;
            4'd1: segDecode = 7'b0110000;
            4'd2: segDecode = 7'b1101101;
            4'd3: segDecode = 7'b1111001;
            4'd4: segDecode = 7'b0110011;
            4'd5: segDecode = 7'b1011011;
            4'd6: segDecode = 7'b1011111;
            4'd7: segDecode = 7'b1110000;
            4'd8: segDecode = 7'b1111111;
            4'd9: segDecode = 7'b1111011;
            default: segDecode = 7'b0000000;
        endcase
    endfunction

    function automatic logic inR(input logic [11:0] v, input logic [11:0] lo, input logic [11:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    // Frame detect; flops reset high so releasing reset with VS idle is not a frame
    logic vsMeta, vsSync, vsPrev, frameEvt;
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            vsMeta <= 1'b1;
            vsSync <= 1'b1;
            vsPrev <= 1'b1;
        end else begin
            vsMeta <= iVS;
            vsSync <= vsMeta;
            vsPrev <= vsSync;
        end
    end
    assign frameEvt = vsPrev & ~vsSync;

    logic [FC_W-1:0] frameCnt;
    logic [15:0]     count, dispCnt;
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            frameCnt <= '0;
            count    <= '0;
            dispCnt  <= '0;
        end else begin
            if (frameEvt) dispCnt <= count;
            if (iLOAD) begin
                count    <= bcdClean(iLOAD_VAL);
                frameCnt <= '0;
            end else if (frameEvt && iRUN) begin
                if (frameCnt == FC_MAX) begin
                    frameCnt <= '0;
                    count    <= bcdInc(count);
                end else begin
                    frameCnt <= frameCnt + 1'b1;
                end
            end
        end
    end
    assign oCOUNT = count;

    // Stage 1: locate the digit cell; underflowed coordinates never match
    logic [11:0] rx, ly, lxD, lxSel;
    logic        inX, inY;
    logic [1:0]  digSel;
    always_comb begin
        rx     = iX - OX;
        ly     = iY - OY;
        inY    = (iY >= OY) && (ly < CELL_H);
        inX    = 1'b0;
        digSel = 2'd0;
        lxSel  = '0;
        lxD    = '0;
        for (int d = 0; d < 4; d++) begin
            lxD = rx - 12'(d*DIG_PITCH);
            if ((iX >= OX) && (rx >= 12'(d*DIG_PITCH)) && (lxD < CELL_W)) begin
                inX    = 1'b1;
                digSel = 2'(d);
                lxSel  = lxD;
            end
        end
    end

    logic        s1In;
    logic [1:0]  s1Dig;
    logic [11:0] s1Lx, s1Ly;
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1In  <= 1'b0;
            s1Dig <= '0;
            s1Lx  <= '0;
            s1Ly  <= '0;
        end else begin
            s1In  <= inX && inY;
            s1Dig <= digSel;
            s1Lx  <= lxSel;
            s1Ly  <= ly;
        end
    end

    // Stage 2: segment hit against the frame-stable displayed count
    logic [3:0] nib;
    logic [6:0] segOn, segIn;
    logic       hit;
    always_comb begin
        nib      = dispCnt[(3 - s1Dig)*4 +: 4];
        segOn    = segDecode(nib);
        segIn[6] = inR(s1Lx, T, T+L)       && inR(s1Ly, 12'd0, T);
        segIn[5] = inR(s1Lx, T+L, 2*T+L)   && inR(s1Ly, T, T+L);
        segIn[4] = inR(s1Lx, T+L, 2*T+L)   && inR(s1Ly, 2*T+L, 2*T+2*L);
        segIn[3] = inR(s1Lx, T, T+L)       && inR(s1Ly, 2*T+2*L, 3*T+2*L);
        segIn[2] = inR(s1Lx, 12'd0, T)     && inR(s1Ly, 2*T+L, 2*T+2*L);
        segIn[1] = inR(s1Lx, 12'd0, T)     && inR(s1Ly, T, T+L);
        segIn[0] = inR(s1Lx, T, T+L)       && inR(s1Ly, T+L, 2*T+L);
        hit      = s1In && |(segOn & segIn);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
        end else begin
            oRed   <= hit ? FG_R : BG_R;
            oGreen <= hit ? FG_G : BG_G;
            oBlue  <= hit ? FG_B : BG_B;
        end
    end
endmodule

// File: tb/tb_vga_ssd_render.sv
// Directed bench for vga_ssd_render: counting, loads, reset and pixel probes
// with hand-computed expectations for the default geometry.
module tb_vga_ssd_render;
    logic        iCLK, iRST, iVS, iRUN, iLOAD;
    logic [11:0] iX, iY;
    logic [15:0] iLOAD_VAL;
    logic [9:0]  oRed, oGreen, oBlue;
    logic [15:0] oCOUNT;

    localparam logic [29:0] FG = {10'h3FF, 10'h000, 10'h000};
    localparam logic [29:0] BG = {10'h000, 10'h000, 10'h0FF};

    int checks = 0;
    int failures = 0;

    vga_ssd_render dut (
        .iCLK(iCLK), .iRST(iRST), .iX(iX), .iY(iY), .iVS(iVS), .iRUN(iRUN),
        .iLOAD(iLOAD), .iLOAD_VAL(iLOAD_VAL),
        .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oCOUNT(oCOUNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            iVS = 1'b0;
            repeat (3) step();
            iVS = 1'b1;
            repeat (3) step();
        end
    endtask

    task automatic load(input logic [15:0] v);
        iLOAD     = 1'b1;
        iLOAD_VAL = v;
        step();
        iLOAD     = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [29:0] exp);
        iX = 12'(x);
        iY = 12'(y);
        step();
        step();
        chk(tag, {2'b00, oRed, oGreen, oBlue}, {2'b00, exp});
    endtask

    initial begin
        iRST = 1'b1; iX = '0; iY = '0; iVS = 1'b1;
        iRUN = 1'b0; iLOAD = 1'b0; iLOAD_VAL = '0;
        step(); step();
        chk("rst_count", 32'(oCOUNT), 32'h0);
        chk("rst_colour", {2'b00, oRed, oGreen, oBlue}, 32'h0);
        iRST = 1'b0;
        step(); step();

        // Exact two-cycle latency: (72,160) is segment a of digit 0 showing '0'
        iX = 12'd72; iY = 12'd160;
        step();
        chk("lat_cyc1_bg", {2'b00, oRed, oGreen, oBlue}, {2'b00, BG});
        iX = 12'd0; iY = 12'd0;
        step();
        chk("lat_cyc2_fg", {2'b00, oRed, oGreen, oBlue}, {2'b00, FG});
        step();
        chk("origin_bg", {2'b00, oRed, oGreen, oBlue}, {2'b00, BG});

        iRUN = 1'b1;
        frames(59);  chk("cnt_59", 32'(oCOUNT), 32'h0000);
        frames(1);   chk("cnt_60", 32'(oCOUNT), 32'h0001);
        frames(540); chk("cnt_600", 32'(oCOUNT), 32'h0010);

        load(16'h9999); chk("load_9999", 32'(oCOUNT), 32'h9999);
        frames(59);     chk("wrap_hold", 32'(oCOUNT), 32'h9999);
        frames(1);      chk("wrap_0000", 32'(oCOUNT), 32'h0000);

        load(16'h12AF); chk("load_clean", 32'(oCOUNT), 32'h1200);

        // Load coinciding with the 60th frame event
        load(16'h0000);
        frames(59);
        iVS = 1'b0;
        step(); step();
        iLOAD = 1'b1; iLOAD_VAL = 16'h4321;
        step();
        iLOAD = 1'b0;
        chk("load_wins", 32'(oCOUNT), 32'h4321);
        iVS = 1'b1;
        repeat (3) step();
        frames(59); chk("fc_cleared", 32'(oCOUNT), 32'h4321);
        frames(1);  chk("tick_after_load", 32'(oCOUNT), 32'h4322);

        // Rendering of 0001; digit 3 origin x=352
        iRUN = 1'b0;
        load(16'h0001);
        frames(1);
        probe("d3_g_off", 384, 220, BG);
        probe("d3_b_on",  412, 192, FG);
        probe("d3_gap",   417, 192, BG);
        probe("d0_a_on",  72, 160, FG);
        probe("d0_g_off", 96, 220, BG);

        // Displayed count only changes on a frame event
        load(16'h0008);
        probe("disp_hold", 384, 220, BG);
        frames(1);
        probe("disp_upd", 384, 220, FG);

        probe("above_org", 72, 159, BG);
        probe("left_org",  63, 180, BG);
        probe("f_edge",    64, 180, FG);
        probe("d_last",    72, 279, FG);
        probe("below_cell", 72, 280, BG);

        // Reset on the cycle the 60th event would tick 0005 -> 0006
        iRUN = 1'b1;
        load(16'h0005);
        frames(59);
        iVS = 1'b0;
        step(); step();
        iRST = 1'b1; iVS = 1'b1;
        step();
        chk("rst_mid_count", 32'(oCOUNT), 32'h0000);
        chk("rst_mid_colour", {2'b00, oRed, oGreen, oBlue}, 32'h0);
        iRST = 1'b0;
        repeat (3) step();
        frames(59); chk("rst_no_spurious", 32'(oCOUNT), 32'h0000);
        frames(1);  chk("rst_fc_zero", 32'(oCOUNT), 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_ssd_render.md
VGA_SSD_RENDER -- requirements
Module: vga_ssd_render

Interface
REQ-001 Parameter ORG_X, default 64: X of the display's top-left pixel.
REQ-002 Parameter ORG_Y, default 160: Y of the display's top-left pixel.
REQ-003 Parameter SEG_T, default 8: segment thickness in pixels.
REQ-004 Parameter SEG_L, default 48: segment length in pixels.
REQ-005 Parameter DIG_PITCH, default 96: X distance between digit origins; DIG_PITCH SHALL be at least SEG_L+2*SEG_T.
REQ-006 Parameter FRAMES_PER_TICK, default 60: number of frames per count increment.
REQ-007 Parameters FG_R/FG_G/FG_B, default 10'h3FF/10'h000/10'h000, and BG_R/BG_G/BG_B, default 10'h000/10'h000/10'h0FF: segment and background colours.
REQ-008 iCLK  in  1: pixel clock, the same clock as the VGA timing controller.
REQ-009 iRST  in  1: reset; one clock; reset is synchronous and active-high.
REQ-010 iX  in  12: current pixel X from the timing controller.
REQ-011 iY  in  12: current pixel Y from the timing controller.
REQ-012 iVS  in  1: vertical sync (active low), asynchronous to the block's pipeline.
REQ-013 iRUN  in  1: when high, frame counting is enabled.
REQ-014 iLOAD  in  1: single-cycle strobe that loads iLOAD_VAL.
REQ-015 iLOAD_VAL  in  16: four BCD digits, MSD in [15:12].
REQ-016 oRed/oGreen/oBlue  out  10 each: pixel colour to the timing controller.
REQ-017 oCOUNT  out  16: current BCD count.

Function
REQ-018 Frame detect: iVS SHALL pass through a 2-FF synchroniser; a 1->0 transition of the synchronised signal is one frame event.
REQ-019 Frame counter: on a frame event with iRUN=1, frame_cnt SHALL increment; at FRAMES_PER_TICK-1 it SHALL wrap to 0 and issue one count increment.
REQ-020 With iRUN=0, frame_cnt and the count SHALL hold.
REQ-021 BCD increment: a digit at 9 SHALL go to 0 and carry to the next digit; 9999 SHALL wrap to 0000.
REQ-022 iLOAD SHALL take priority over an increment in the same cycle; the loaded value SHALL appear on oCOUNT the next cycle, and frame_cnt SHALL clear to 0.
REQ-023 Any loaded nibble greater than 9 SHALL be stored as 0.
REQ-024 Geometry, with T=SEG_T and L=SEG_L: a cell is L+2T wide and 2L+3T tall; digit d (0 = MSD) occupies lx = iX-ORG_X-d*DIG_PITCH and ly = iY-ORG_Y.
REQ-025 Segment rectangles, half-open [lo,hi):
- a: lx[T,T+L), ly[0,T)
- b: lx[T+L,2T+L), ly[T,T+L)
- c: lx[T+L,2T+L), ly[2T+L,2T+2L)
- d: lx[T,T+L), ly[2T+2L,3T+2L)
- e: lx[0,T), ly[2T+L,2T+2L)
- f: lx[0,T), ly[T,T+L)
- g: lx[T,T+L), ly[T+L,2T+L)
REQ-026 Standard 7-segment decode SHALL apply to 0-9 (for example, 1 = b,c and 7 = a,b,c).
REQ-027 A pixel SHALL take FG colour if it lies in a lit segment of any digit; otherwise it SHALL take BG colour.
REQ-028 A pixel left of ORG_X, above ORG_Y, below the cell, or in the inter-digit gap SHALL be BG colour.
REQ-029 Pipeline: stage 1 SHALL register iX/iY and the digit index/local coordinates; stage 2 SHALL register the segment hit and the colour. Latency from iX/iY to colour SHALL be exactly 2 cycles at 1 pixel per clock with no stalls, giving a fixed 2-pixel right shift.
REQ-030 The count used for rendering SHALL be sampled once per frame event, so a change to the displayed count never occurs mid-frame.
REQ-031 All coordinate arithmetic SHALL be unsigned 12-bit; negative local coordinates (underflow) SHALL be treated as outside the cell.

Reset
REQ-032 While iRST=1 at a rising edge of iCLK:
- oRed/oGreen/oBlue = 0
- oCOUNT = 0000
- frame_cnt = 0
- the displayed count = 0000
- synchroniser flops = 1, so there is no false frame event on reset release
- pipeline registers = 0
REQ-033 Reset asserted mid-frame SHALL take effect on the next edge, overriding iLOAD and any increment.

Verification
REQ-034 Reset, then iX=ORG_X+T, iY=ORG_Y for 1 cycle -> FG colour (segment a of 0) appears 2 cycles later; iX=0,iY=0 -> BG colour.
REQ-035 iRUN=1, 60 iVS falling edges -> oCOUNT=0001; 600 edges -> 0010.
REQ-036 Load 16'h9999, then 60 frames -> oCOUNT=0000.
REQ-037 iLOAD with 16'h12AF -> oCOUNT=1200; iLOAD and a tick in the same cycle -> the loaded value wins.
REQ-038 Count 0001, probe digit 3 at segment g centre (lx=T+L/2, ly=T+L+T/2) -> BG; probe segment b -> FG; probe inter-digit gap lx=L+2T+1 -> BG.
REQ-039 iRST asserted during the frame_cnt=59 cycle with iVS falling edge -> oCOUNT=0000, frame_cnt=0, and no spurious frame event after release.
